// File: rtl/kriptografi_denetleyici_if.sv
// Issue / unit / writeback signal bundle for the crypto issue controller.
// master = the controller itself, slave = its environment (issue, unit, writeback).
interface kriptografi_denetleyici_if;
    logic        bosalt_i;
    logic        istek_gecerli_i;
    logic        istek_hazir_o;
    logic [2:0]  islem_kodu_i;
    logic [31:0] yazmac_rs1_i;
    logic [31:0] yazmac_rs2_i;
    logic [4:0]  hedef_yazmac_i;
    logic        blok_aktif_o;
    logic [2:0]  birim_islem_kodu_o;
    logic [31:0] birim_rs1_o;
    logic [31:0] birim_rs2_o;
    logic [31:0] birim_sonuc_i;
    logic        birim_hazir_i;
    logic        sonuc_gecerli_o;
    logic        sonuc_hazir_i;
    logic [31:0] sonuc_o;
    logic [4:0]  sonuc_hedef_o;
    logic        hata_o;
    logic        zaman_asimi_o;

    modport master (
        input  bosalt_i, istek_gecerli_i, islem_kodu_i, yazmac_rs1_i, yazmac_rs2_i,
               hedef_yazmac_i, birim_sonuc_i, birim_hazir_i, sonuc_hazir_i,
        output istek_hazir_o, blok_aktif_o, birim_islem_kodu_o, birim_rs1_o, birim_rs2_o,
               sonuc_gecerli_o, sonuc_o, sonuc_hedef_o, hata_o, zaman_asimi_o
    );

    modport slave (
        output bosalt_i, istek_gecerli_i, islem_kodu_i, yazmac_rs1_i, yazmac_rs2_i,
               hedef_yazmac_i, birim_sonuc_i, birim_hazir_i, sonuc_hazir_i,
        input  istek_hazir_o, blok_aktif_o, birim_islem_kodu_o, birim_rs1_o, birim_rs2_o,
               sonuc_gecerli_o, sonuc_o, sonuc_hedef_o, hata_o, zaman_asimi_o
    );
endinterface

// File: rtl/kriptografi_denetleyici.sv
// Issue-side initiator for the execute-stage crypto unit: accepts one
// instruction, enables the unit until it answers or times out, then holds
// the result (or an error) for writeback.
module kriptografi_denetleyici #(
    parameter int ZAMAN_ASIMI     = 64,
    parameter int SAYAC_GENISLIGI = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    kriptografi_denetleyici_if.master  bus
);

    typedef enum logic [1:0] {
        BOSTA     = 2'd0,
        CALISIYOR = 2'd1,
        SONUC     = 2'd2
    } durum_t;

    localparam logic [SAYAC_GENISLIGI-1:0] SON_SAYAC = SAYAC_GENISLIGI'(ZAMAN_ASIMI - 1);
    localparam logic [SAYAC_GENISLIGI-1:0] DOYMA     = {SAYAC_GENISLIGI{1'b1}};

    durum_t                     durum_q, durum_d;
    logic [SAYAC_GENISLIGI-1:0] sayac_q, sayac_d;
    logic [2:0]                 kod_q, kod_d;
    logic [31:0]                rs1_q, rs1_d;
    logic [31:0]                rs2_q, rs2_d;
    logic [4:0]                 hedef_q, hedef_d;
    logic [31:0]                sonuc_q, sonuc_d;
    logic                       hata_q, hata_d;
    logic                       zaman_q, zaman_d;

    logic kod_gecerli;
    assign kod_gecerli = (bus.islem_kodu_i <= 3'b101);

    // Next-state logic; flush overrides every other decision taken below.
    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        kod_d   = kod_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        hedef_d = hedef_q;
        sonuc_d = sonuc_q;
        hata_d  = hata_q;
        zaman_d = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (bus.istek_gecerli_i && !bus.bosalt_i) begin
                    kod_d   = bus.islem_kodu_i;
                    rs1_d   = bus.yazmac_rs1_i;
                    rs2_d   = bus.yazmac_rs2_i;
                    hedef_d = bus.hedef_yazmac_i;
                    if (kod_gecerli) begin
                        durum_d = CALISIYOR;
                        sayac_d = '0;
                    end else begin
                        // Invalid opcodes never reach the unit.
                        durum_d = SONUC;
                        sonuc_d = '0;
                        hata_d  = 1'b1;
                    end
                end
            end
            CALISIYOR: begin
                if (sayac_q != DOYMA) begin
                    sayac_d = sayac_q + 1'b1;
                end
                if (bus.birim_hazir_i) begin
                    // The unit drops its result once disabled, so grab it now.
                    durum_d = SONUC;
                    sonuc_d = bus.birim_sonuc_i;
                    hata_d  = 1'b0;
                end else if (sayac_q == SON_SAYAC) begin
                    durum_d = SONUC;
                    sonuc_d = '0;
                    hata_d  = 1'b1;
                    zaman_d = 1'b1;
                end
            end
            SONUC: begin
                if (bus.sonuc_hazir_i) begin
                    durum_d = BOSTA;
                end
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase

        if (bus.bosalt_i) begin
            durum_d = BOSTA;
            zaman_d = 1'b0;
        end
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q <= BOSTA;
            sayac_q <= '0;
            kod_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            hedef_q <= '0;
            sonuc_q <= '0;
            hata_q  <= 1'b0;
            zaman_q <= 1'b0;
        end else begin
            durum_q <= durum_d;
            sayac_q <= sayac_d;
            kod_q   <= kod_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            hedef_q <= hedef_d;
            sonuc_q <= sonuc_d;
            hata_q  <= hata_d;
            zaman_q <= zaman_d;
        end
    end

    // Outputs are decoded from the registered state, so reset drops them at once.
    // Operands are shown to the unit only while it is enabled, and the result
    // fields only while they are being offered to writeback.
    assign bus.istek_hazir_o      = (durum_q == BOSTA) && !bus.bosalt_i && rst_i;
    assign bus.blok_aktif_o       = (durum_q == CALISIYOR);
    assign bus.birim_islem_kodu_o = bus.blok_aktif_o ? kod_q : 3'b000;
    assign bus.birim_rs1_o        = bus.blok_aktif_o ? rs1_q : 32'h0;
    assign bus.birim_rs2_o        = bus.blok_aktif_o ? rs2_q : 32'h0;
    assign bus.sonuc_gecerli_o    = (durum_q == SONUC);
    assign bus.sonuc_o            = bus.sonuc_gecerli_o ? sonuc_q : 32'h0;
    assign bus.sonuc_hedef_o      = bus.sonuc_gecerli_o ? hedef_q : 5'd0;
    assign bus.hata_o             = bus.sonuc_gecerli_o && hata_q;
    assign bus.zaman_asimi_o      = zaman_q;

endmodule

// File: tb/tb_kriptografi_denetleyici.sv
// Directed bench for kriptografi_denetleyici: an operation-level reference
// model checked every cycle, a simple crypto-unit responder, and literal
// expectations for each scenario.
module tb_kriptografi_denetleyici;

    localparam int ZA = 8;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   n_ass = 0;
    int   n_fail = 0;

    kriptografi_denetleyici_if bif ();

    kriptografi_denetleyici #(
        .ZAMAN_ASIMI     (ZA),
        .SAYAC_GENISLIGI (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;

    // Reference behaviour of the crypto unit itself.
    function automatic logic [31:0] birim_hesap(input logic [2:0] k, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (k)
            3'b000: r = 32'($countones(a ^ b));
            3'b001: r = {b[15:0], a[15:0]};
            3'b010: for (int i = 0; i < 32; i++) r[31-i] = a[i];
            3'b011: r = (a << 1) + b;
            3'b100: begin
                r = 32'd32;
                for (int i = 31; i >= 0; i--) if (a[i]) r = 32'(i);
            end
            3'b101: r = 32'($countones(a));
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_ass++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", ad, $time, gercek, beklenen);
        end
    endtask

    // Operation-level model: phase 0 idle, 1 unit busy, 2 result offered.
    int          m_faz = 0;
    int          m_yas = 0;
    logic [2:0]  m_kod = '0;
    logic [31:0] m_rs1 = '0, m_rs2 = '0, m_sonuc = '0;
    logic [4:0]  m_hedef = '0;
    logic        m_hata = 1'b0, m_to = 1'b0;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_faz <= 0; m_yas <= 0; m_kod <= '0; m_rs1 <= '0; m_rs2 <= '0;
            m_hedef <= '0; m_sonuc <= '0; m_hata <= 1'b0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (bif.bosalt_i) begin
                m_faz <= 0;
            end else if (m_faz == 0) begin
                if (bif.istek_gecerli_i) begin
                    m_kod <= bif.islem_kodu_i; m_rs1 <= bif.yazmac_rs1_i;
                    m_rs2 <= bif.yazmac_rs2_i; m_hedef <= bif.hedef_yazmac_i;
                    if (bif.islem_kodu_i > 3'd5) begin
                        m_faz <= 2; m_sonuc <= 32'h0; m_hata <= 1'b1;
                    end else begin
                        m_faz <= 1; m_yas <= 0;
                    end
                end
            end else if (m_faz == 1) begin
                // m_yas counts busy cycles already completed
                m_yas <= m_yas + 1;
                if (bif.birim_hazir_i) begin
                    m_faz <= 2; m_sonuc <= birim_hesap(m_kod, m_rs1, m_rs2); m_hata <= 1'b0;
                end else if (m_yas + 1 == ZA) begin
                    m_faz <= 2; m_sonuc <= 32'h0; m_hata <= 1'b1; m_to <= 1'b1;
                end
            end else begin
                if (bif.sonuc_hazir_i) m_faz <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        chk("m_istek_hazir", 32'(bif.istek_hazir_o), 32'(rst_i && m_faz == 0 && !bif.bosalt_i));
        chk("m_blok_aktif", 32'(bif.blok_aktif_o), 32'(m_faz == 1));
        chk("m_sonuc_gecerli", 32'(bif.sonuc_gecerli_o), 32'(m_faz == 2));
        chk("m_zaman_asimi", 32'(bif.zaman_asimi_o), 32'(m_to));
        if (m_faz != 2) begin
            chk("m_birim_kod", 32'(bif.birim_islem_kodu_o), (m_faz == 1) ? 32'(m_kod) : 32'h0);
            chk("m_birim_rs1", bif.birim_rs1_o, (m_faz == 1) ? m_rs1 : 32'h0);
            chk("m_birim_rs2", bif.birim_rs2_o, (m_faz == 1) ? m_rs2 : 32'h0);
        end
        if (m_faz != 1) begin
            chk("m_sonuc", bif.sonuc_o, (m_faz == 2) ? m_sonuc : 32'h0);
            chk("m_hedef", 32'(bif.sonuc_hedef_o), (m_faz == 2) ? 32'(m_hedef) : 32'h0);
            chk("m_hata", 32'(bif.hata_o), (m_faz == 2) ? 32'(m_hata) : 32'h0);
        end
    end

    // Crypto unit stand-in: answers on the unit_delay-th enabled cycle.
    int unit_delay = 2;
    bit unit_en = 1'b1;
    initial begin
        int u_cnt;
        u_cnt = 0;
        bif.birim_hazir_i = 1'b0;
        bif.birim_sonuc_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.blok_aktif_o) u_cnt++;
            else u_cnt = 0;
            bif.birim_hazir_i = unit_en && bif.blok_aktif_o && (u_cnt == unit_delay);
            bif.birim_sonuc_i = bif.birim_hazir_i ?
                birim_hesap(bif.birim_islem_kodu_o, bif.birim_rs1_o, bif.birim_rs2_o) : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then withdraw it.
    task automatic istek(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] h, input string ad);
        bif.istek_gecerli_i = 1'b1;
        bif.islem_kodu_i = k; bif.yazmac_rs1_i = a; bif.yazmac_rs2_i = b; bif.hedef_yazmac_i = h;
        chk({ad, "_istek_hazir"}, 32'(bif.istek_hazir_o), 32'd1);
        tick();
        bif.istek_gecerli_i = 1'b0;
        $display("istek %s: kod=%b rs1=%h rs2=%h hedef=%0d", ad, k, a, b, h);
    endtask

    task automatic bekle_sonuc(input int sinir, input string ad);
        int n;
        n = 0;
        while (!bif.sonuc_gecerli_o && n < sinir) begin
            tick();
            n++;
        end
        chk({ad, "_sonuc_bekleme"}, 32'(bif.sonuc_gecerli_o), 32'd1);
    endtask

    initial begin
        int sayi;
        bif.bosalt_i = 1'b0; bif.istek_gecerli_i = 1'b0; bif.islem_kodu_i = '0;
        bif.yazmac_rs1_i = '0; bif.yazmac_rs2_i = '0; bif.hedef_yazmac_i = '0;
        bif.sonuc_hazir_i = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_blok", 32'(bif.blok_aktif_o), 32'd0);
        chk("rst_gecerli", 32'(bif.sonuc_gecerli_o), 32'd0);
        chk("rst_istek_hazir", 32'(bif.istek_hazir_o), 32'd0);
        chk("rst_sonuc", bif.sonuc_o, 32'h0);
        @(negedge clk); #2; rst_i = 1'b1;
        tick();

        // 1: pkg, unit ready at cycle 2
        unit_en = 1'b1; unit_delay = 2; bif.sonuc_hazir_i = 1'b1;
        istek(3'b001, 32'h0000ABCD, 32'h00001234, 5'd5, "t1");
        chk("t1_c1_blok", 32'(bif.blok_aktif_o), 32'd1);
        tick();
        chk("t1_c2_blok", 32'(bif.blok_aktif_o), 32'd1);
        tick();
        chk("t1_c3_gecerli", 32'(bif.sonuc_gecerli_o), 32'd1);
        chk("t1_c3_sonuc", bif.sonuc_o, 32'h1234ABCD);
        chk("t1_c3_hedef", 32'(bif.sonuc_hedef_o), 32'd5);
        chk("t1_c3_hata", 32'(bif.hata_o), 32'd0);
        chk("t1_c3_blok", 32'(bif.blok_aktif_o), 32'd0);
        tick();
        chk("t1_c4_gecerli", 32'(bif.sonuc_gecerli_o), 32'd0);
        $display("t1 pkg: sonuc=%h", 32'h1234ABCD);

        // 2: backpressure, writeback stalls four cycles
        bif.sonuc_hazir_i = 1'b0;
        istek(3'b001, 32'h0000ABCD, 32'h00001234, 5'd5, "t2");
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bif.sonuc_hazir_i = 1'b1;
            chk("t2_gecerli", 32'(bif.sonuc_gecerli_o), 32'd1);
            chk("t2_sonuc", bif.sonuc_o, 32'h1234ABCD);
            chk("t2_hedef", 32'(bif.sonuc_hedef_o), 32'd5);
            chk("t2_istek_hazir", 32'(bif.istek_hazir_o), 32'd0);
            chk("t2_blok", 32'(bif.blok_aktif_o), 32'd0);
            tick();
        end
        chk("t2_bosta", 32'(bif.sonuc_gecerli_o), 32'd0);
        $display("t2 backpressure: 5 held cycles");

        // 3: timeout, unit never answers
        unit_en = 1'b0; bif.sonuc_hazir_i = 1'b0;
        istek(3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd7, "t3");
        sayi = 0;
        for (int n = 0; n < 40 && !bif.sonuc_gecerli_o; n++) begin
            if (bif.blok_aktif_o) sayi++;
            tick();
        end
        chk("t3_sonuc_bekleme", 32'(bif.sonuc_gecerli_o), 32'd1);
        chk("t3_blok_sure", 32'(sayi), 32'(ZA));
        chk("t3_zaman_asimi", 32'(bif.zaman_asimi_o), 32'd1);
        chk("t3_hata", 32'(bif.hata_o), 32'd1);
        chk("t3_sonuc", bif.sonuc_o, 32'h0);
        tick();
        chk("t3_darbe_sonu", 32'(bif.zaman_asimi_o), 32'd0);
        chk("t3_gecerli_tut", 32'(bif.sonuc_gecerli_o), 32'd1);
        bif.sonuc_hazir_i = 1'b1;
        tick();
        chk("t3_bosta", 32'(bif.sonuc_gecerli_o), 32'd0);
        $display("t3 timeout: blok cycles=%0d", sayi);

        // 4: invalid opcode
        unit_en = 1'b1; bif.sonuc_hazir_i = 1'b0;
        istek(3'b111, 32'hFFFFFFFF, 32'h0, 5'd9, "t4");
        chk("t4_blok", 32'(bif.blok_aktif_o), 32'd0);
        chk("t4_gecerli", 32'(bif.sonuc_gecerli_o), 32'd1);
        chk("t4_hata", 32'(bif.hata_o), 32'd1);
        chk("t4_sonuc", bif.sonuc_o, 32'h0);
        chk("t4_hedef", 32'(bif.sonuc_hedef_o), 32'd9);
        bif.sonuc_hazir_i = 1'b1;
        tick();
        chk("t4_bosta", 32'(bif.sonuc_gecerli_o), 32'd0);
        $display("t4 invalid opcode: hata=1");

        // 5: flush together with unit ready and a new request
        unit_delay = 2;
        istek(3'b001, 32'h00005555, 32'h0000AAAA, 5'd2, "t5");
        tick();
        bif.bosalt_i = 1'b1; bif.istek_gecerli_i = 1'b1; bif.islem_kodu_i = 3'b010;
        #1;
        chk("t5_c2_istek_hazir", 32'(bif.istek_hazir_o), 32'd0);
        tick();
        bif.bosalt_i = 1'b0; bif.istek_gecerli_i = 1'b0;
        #1;
        chk("t5_c3_blok", 32'(bif.blok_aktif_o), 32'd0);
        chk("t5_c3_gecerli", 32'(bif.sonuc_gecerli_o), 32'd0);
        chk("t5_c3_istek_hazir", 32'(bif.istek_hazir_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t5_sonuc_yok", 32'(bif.sonuc_gecerli_o), 32'd0);
        end
        $display("t5 flush: result discarded");

        // 6: asynchronous reset mid-operation, then rvrs
        unit_en = 1'b0;
        istek(3'b000, 32'h1, 32'h2, 5'd4, "t6a");
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_rst_blok", 32'(bif.blok_aktif_o), 32'd0);
        chk("t6_rst_gecerli", 32'(bif.sonuc_gecerli_o), 32'd0);
        @(negedge clk); #2; rst_i = 1'b1;
        tick();
        unit_en = 1'b1; unit_delay = 1;
        istek(3'b010, 32'h00000001, 32'h0, 5'd3, "t6b");
        bekle_sonuc(20, "t6");
        chk("t6_sonuc", bif.sonuc_o, 32'h80000000);
        chk("t6_hata", 32'(bif.hata_o), 32'd0);
        chk("t6_hedef", 32'(bif.sonuc_hedef_o), 32'd3);
        tick();
        $display("t6 reset+rvrs: sonuc=%h", 32'h80000000);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
